// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out serializer.
// The optional parity bit is enabled with the PISO_PARITY_EN macro.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam int PISO_WIDTH_DEF = 4;

    // Counter must hold values 0..WIDTH, the extra value covering the parity slot
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: clear on word accept, increment per shifted bit,
// flags when the count equals the supplied terminal count.
module piso_bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic [CW-1:0] tc_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins over increment so a chained accept restarts the frame at 0
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i)
            cnt_d = cnt_q + 1'b1;
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == tc_i);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, MSB first, feeding a downstream SIPO.
// Words arrive on a valid/ready handshake; back-to-back frames have no gap.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

`ifdef PISO_PARITY_EN
    // Frame ends on the parity slot, one past the last data bit
    localparam logic [CW-1:0] TC = CW'(WIDTH);
`else
    localparam logic [CW-1:0] TC = CW'(WIDTH - 1);
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             frame_last;
    logic             data_last;
    logic             accept;

    // Ready depends only on registered state so no input reaches any output
    assign frame_last = last && (state_q != IDLE);
    assign data_last  = (state_q == SHIFT) && (cnt == CW'(WIDTH - 1));
    assign load_ready = (state_q == IDLE) || frame_last;
    assign accept     = load_valid && load_ready && !rst;

    piso_bit_counter #(
        .CW (CW)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (accept),
        .inc_i  ((state_q == SHIFT) && !accept),
        .tc_i   (TC),
        .cnt_o  (cnt),
        .last_o (last)
    );

    // Next-state and shift-register update
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        if (accept)
            sreg_d = load_data;
        else if (state_q == SHIFT)
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = SHIFT;
            end
            SHIFT: begin
                if (data_last) begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = accept ? SHIFT : IDLE;
`endif
                end
            end
            PARITY: begin
                state_d = accept ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

`ifdef PISO_PARITY_EN
    logic par_q;

    // Parity of the accepted word, held for the trailing parity slot
    always_ff @(posedge clk) begin
        if (rst)
            par_q <= 1'b0;
        else if (accept)
            par_q <= ^load_data;
    end
`endif

    // Serial output mux, forced low outside a frame
    always_comb begin
        sout = 1'b0;
        case (state_q)
            SHIFT:  sout = sreg_q[WIDTH-1];
`ifdef PISO_PARITY_EN
            PARITY: sout = par_q;
`endif
            default: sout = 1'b0;
        endcase
    end

    assign sout_valid = (state_q != IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = frame_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer (WIDTH=4), with a chained 4-bit SIPO.
// Handles both builds: PISO_PARITY_EN defined or not.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int FRAME = 5;
`else
    localparam bit PAR = 1'b0;
    localparam int FRAME = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] load_data = 4'hF;
    logic       load_valid = 1'b1;
    logic       load_ready;
    logic       sout;
    logic       sout_valid;
    logic       busy;
    logic       done;

    // entry = {word[3:0], bit, last, word_end}
    logic [6:0] exp_q[$];
    logic [3:0] sipo_q = 4'h0;
    logic [3:0] sipo_word = 4'h0;
    bit         sipo_pend = 1'b0;
    bit         mon_en = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    piso_serializer #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sipo_q <= {sipo_q[2:0], sout};

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0b required %0b at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares every cycle's outputs against the scoreboard head
    always @(negedge clk) begin
        logic [6:0] e;
        if (mon_en) begin
            if (sipo_pend) begin
                check("sipo_word", sipo_q, sipo_word);
                sipo_pend = 1'b0;
            end
            check("load_ready", {3'b0, load_ready}, {3'b0, exp_q.size() <= 1});
            check("sout_valid", {3'b0, sout_valid}, {3'b0, exp_q.size() != 0});
            check("busy", {3'b0, busy}, {3'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sout", {3'b0, sout}, {3'b0, e[2]});
                check("done", {3'b0, done}, {3'b0, e[1]});
                if (e[0]) begin
                    sipo_pend = 1'b1;
                    sipo_word = e[6:3];
                end
            end else begin
                check("idle_sout", {3'b0, sout}, 4'h0);
                check("idle_done", {3'b0, done}, 4'h0);
            end
        end
    end

    // exp = {hand-computed data bits MSB first, hand-computed parity}
    task automatic push_frame(input logic [3:0] w, input logic [4:0] exp);
        for (int i = 4; i >= 1; i--)
            exp_q.push_back({w, exp[i], (i == 1) && !PAR, i == 1});
        if (PAR)
            exp_q.push_back({w, exp[0], 1'b1, 1'b0});
    endtask

    // One cycle of stimulus, applied just after the falling edge
    task automatic step(input logic v, input logic [3:0] d, input logic r,
                        input logic [4:0] exp, output bit acc);
        @(negedge clk);
        #1;
        load_valid = v;
        load_data  = d;
        rst        = r;
        acc = v && !r && (exp_q.size() == 0);
        if (acc)
            push_frame(d, exp);
        if (r)
            exp_q.delete();
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++)
            step(1'b0, 4'hE, 1'b0, 5'b0, a);
    endtask

    // Hold load_valid until the word is taken, bounded
    task automatic send(input logic [3:0] w, input logic [4:0] exp);
        bit a;
        int k;
        a = 1'b0;
        k = 0;
        while (!a && k < 10) begin
            step(1'b1, w, 1'b0, exp, a);
            k++;
        end
        n_checks++;
        if (!a) begin
            n_fail++;
            $display("FAIL send_timeout: got no accept required accept of %0h", w);
        end
    endtask

    initial begin
        bit a;
        // Reset with valid high and data F: nothing may be accepted
        step(1'b1, 4'hF, 1'b1, 5'b0, a);
        step(1'b1, 4'hF, 1'b1, 5'b0, a);
        mon_en = 1'b1;
        step(1'b1, 4'hF, 1'b1, 5'b0, a);
        idle(1);
        // Single word
        send(4'b1011, 5'b1011_1);
        idle(FRAME + 1);
        // Back-to-back with load_valid held
        send(4'hA, 5'b1010_0);
        send(4'h5, 5'b0101_0);
        send(4'b1001, 5'b1001_0);
        idle(FRAME + 1);
        // Stall: valid low over the last bit and one more cycle
        send(4'b0011, 5'b0011_0);
        idle(FRAME + 1);
        send(4'b0111, 5'b0111_1);
        idle(FRAME + 1);
        // Reset in the second bit cycle of a frame
        send(4'b1100, 5'b1100_0);
        idle(1);
        step(1'b0, 4'hE, 1'b1, 5'b0, a);
        idle(2);
        send(4'b0110, 5'b0110_0);
        idle(FRAME + 2);
        check("drained", 4'(exp_q.size()), 4'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in serial-out serializer that sits directly upstream of the 4-bit SIPO shift register and drives its serial `d` input. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, MSB first, with a `sout_valid` qualifier. Back-to-back words stream with no idle gap. After WIDTH data edges the downstream SIPO holds the word on its parallel output.

## Interface
- `WIDTH`, default 4: data word width; minimum 2.
- `clk`  input  1: rising-edge clock, the only clock.
- `rst`  input  1: synchronous, active-high reset.
- `load_data`  input  WIDTH: parallel word to serialize.
- `load_valid`  input  1: `load_data` is valid this cycle.
- `load_ready`  output  1: the block can accept a word this cycle. Combinational from registered state only, never from `load_valid`.
- `sout`  output  1: serial data out, feeds SIPO `d`.
- `sout_valid`  output  1: `sout` carries a frame bit this cycle.
- `busy`  output  1: a frame is in progress.
- `done`  output  1: single-cycle pulse while the last frame bit is on `sout`.

## Operation
- **Reset values:** `rst` high on an edge forces state IDLE, shift register 0, bit counter 0. This gives `sout`=0, `sout_valid`=0, `busy`=0, `done`=0 and `load_ready`=1 from the first cycle after reset.
- **Reset mid-frame:** the frame is abandoned and no `done` pulse is issued.
- **Inputs during reset:** `load_valid` is ignored in any cycle where `rst` is high.
- **Accept rule:** a word is accepted on an edge where `load_valid && load_ready`. `load_ready` = (state==IDLE) || (state==SHIFT && last bit on `sout`).
- **State machine:**
  - IDLE → SHIFT on accept.
  - SHIFT → SHIFT on the last bit when a new word is accepted on that same edge.
  - SHIFT → IDLE on the last bit with no accept.
  - With `PISO_PARITY_EN` defined, a PARITY state follows SHIFT (see Configuration).
- **Shift path:** on accept, `load_data` loads the shift register and the counter clears. Each SHIFT edge shifts left one bit and increments the counter. `sout` = shift register MSB, so bits go out MSB first.
- **Counter:** width `$clog2(WIDTH+1)`. The last bit is the one where counter == WIDTH-1. The counter never wraps within a frame.
- **Registered outputs:** `sout_valid` = (state != IDLE). `busy` is identical to `sout_valid`. `sout` is 0 whenever `sout_valid` is 0.
- **Upstream stall:** `load_valid` low on the last bit → one IDLE cycle minimum before the next frame.
- **Held data:** `load_data` changing while not accepted has no effect.

## Timing
- **Latency:** accept on edge N → bit WIDTH-1 on `sout` during cycle N+1. Bit 0 is on `sout` during cycle N+WIDTH, with `done`=1 in that cycle.
- **Throughput:** continuous `load_valid` gives one word per WIDTH cycles and `sout_valid` never drops.
- **Downstream capture:** the SIPO samples `sout` on edges N+1 … N+WIDTH. Its parallel output equals the accepted word after edge N+WIDTH.
- **Combinational paths:** no path from any input to any output within a cycle, including `load_ready`.

## Configuration
- `PISO_PARITY_EN` defined:
  - After the last data bit the FSM enters PARITY for one cycle and drives `sout` = even parity (XOR) of the accepted word, with `sout_valid`=1.
  - `done` and the `load_ready` window move to the PARITY cycle.
  - Frame length becomes WIDTH+1 and throughput one word per WIDTH+1 cycles.
- `PISO_PARITY_EN` undefined: no PARITY state, no parity register, frame length WIDTH.

## Structure
- **Package `piso_pkg`:**
  - state encoding: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2.
  - default WIDTH constant 4.
  - counter-width function.
- **Sub-module `piso_bit_counter`:** clear/increment counter with a `last` output compared against a terminal count input. It is instantiated once. The terminal count is WIDTH-1, or WIDTH when parity is enabled.

## Test plan
- **Reset:** hold `rst` 2 cycles with `load_valid`=1 and `load_data`=4'hF → no accept; all outputs at reset values; `load_ready`=1 on the first cycle after reset.
- **Single word:** WIDTH=4, accept 4'b1011 at edge 0 → `sout` = 1,0,1,1 on cycles 1–4; `done` only in cycle 4; IDLE in cycle 5. A chained SIPO reads q=4'b1011 after edge 4.
- **Back-to-back:** 4'hA then 4'h5 with `load_valid` held → `sout` = 1010 0101 over 8 contiguous cycles; `sout_valid` never drops; `done` in cycles 4 and 8.
- **Stall:** `load_valid` low during the last bit, high 2 cycles later → gap cycles show `sout_valid`=0 and `sout`=0; the second frame starts one cycle after its accept.
- **Reset mid-frame:** `rst` pulsed in cycle 2 of frame 4'b1100 → next cycle is IDLE, no `done`; a new word 4'b0110 then serializes correctly.
- **Parity (`PISO_PARITY_EN`):** 4'b1011 → `sout` = 1,0,1,1,1 (parity=1); 4'b1001 → parity 0; `done` on the fifth bit.
